// File: rtl/mult_sequencer_if.sv
// Bundle of the upstream, multiplier-side and downstream signals of the multiply sequencer.
// master is the sequencer's view; slave is the view of the surrounding logic.
interface mult_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        mul_put;
   logic [7:0]  mul_idata;
   logic        mul_ready;
   logic [15:0] mul_result;
   logic        mul_result_valid;
   logic        mul_get;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic [15:0] done_count;
   logic        proto_err;

   modport master (
      input  in_valid, in_a, in_b, mul_ready, mul_result, mul_result_valid, out_ready,
      output in_ready, mul_put, mul_idata, mul_get, out_valid, out_data, done_count, proto_err
   );

   modport slave (
      output in_valid, in_a, in_b, mul_ready, mul_result, mul_result_valid, out_ready,
      input  in_ready, mul_put, mul_idata, mul_get, out_valid, out_data, done_count, proto_err
   );
endinterface

// File: rtl/mult_sequencer.sv
// Queues operand pairs, feeds them byte-wise to a put/get multiplier and
// forwards each 16-bit product downstream through a one-entry output register.
module mult_sequencer #(
   parameter int DEPTH = 4
) (
   input logic            clk,
   input logic            rst_b,
   mult_sequencer_if.master bus
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_RES} state_t;

   state_t           state_q, state_d;
   logic [7:0]       memA_q [DEPTH];
   logic [7:0]       memB_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             outValid_q, outValid_d;
   logic [15:0]      outData_q, outData_d;
   logic [15:0]      doneCount_q, doneCount_d;
   logic             protoErr_q, protoErr_d;

   logic             push, pop, load, consume, protoSet;
   logic             mulPut, mulGet;
   logic [7:0]       mulIdata;

   assign bus.in_ready   = (count_q != DEPTH_C);
   assign push           = bus.in_valid && bus.in_ready;
   assign consume        = outValid_q && bus.out_ready;
   assign protoSet       = (bus.mul_result_valid && ((state_q == SEND_A) || (state_q == SEND_B)))
                        || (!bus.mul_ready && (state_q == IDLE));

   assign bus.mul_put    = mulPut;
   assign bus.mul_idata  = mulIdata;
   assign bus.mul_get    = mulGet;
   assign bus.out_valid  = outValid_q;
   assign bus.out_data   = outData_q;
   assign bus.done_count = doneCount_q;
   assign bus.proto_err  = protoErr_q;

   always_ff @(posedge clk) begin
      if (push) begin
         memA_q[wrPtr_q] <= bus.in_a;
         memB_q[wrPtr_q] <= bus.in_b;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pair bytes are only dropped from the FIFO once the multiplier has taken both.
   always_comb begin
      state_d  = state_q;
      mulPut   = 1'b0;
      mulIdata = 8'h00;
      mulGet   = 1'b0;
      pop      = 1'b0;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) state_d = SEND_A;
         end
         SEND_A: begin
            mulPut   = 1'b1;
            mulIdata = memA_q[rdPtr_q];
            if (bus.mul_ready) state_d = SEND_B;
         end
         SEND_B: begin
            mulPut   = 1'b1;
            mulIdata = memB_q[rdPtr_q];
            if (bus.mul_ready) begin
               pop     = 1'b1;
               state_d = WAIT_RES;
            end
         end
         WAIT_RES: begin
            if (bus.mul_result_valid && (!outValid_q || bus.out_ready)) begin
               mulGet  = 1'b1;
               load    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      outValid_d  = outValid_q;
      outData_d   = outData_q;
      doneCount_d = doneCount_q;
      protoErr_d  = protoErr_q;
      if (consume) begin
         outValid_d  = 1'b0;
         doneCount_d = doneCount_q + 16'd1;
      end
      if (load) begin
         outValid_d = 1'b1;
         outData_d  = bus.mul_result;
      end
      if (protoSet) protoErr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= 16'h0000;
         doneCount_q <= 16'h0000;
         protoErr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         doneCount_q <= doneCount_d;
         protoErr_q  <= protoErr_d;
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural put/get multiplier
// that answers one cycle after receiving its second operand byte.
module tb_mult_sequencer;

   logic clk = 1'b0;
   logic rst_b;

   mult_sequencer_if bus();

   mult_sequencer #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   logic        forceNotReady;
   logic        forceResValid;
   logic        gotA;
   logic        pending;
   logic [7:0]  opA;
   logic [15:0] prod;

   logic [7:0] fillA [5] = '{8'h03, 8'h10, 8'h7F, 8'hFF, 8'h12};
   logic [7:0] fillB [5] = '{8'h05, 8'h10, 8'h02, 8'h01, 8'h34};
   logic [15:0] fillP [5] = '{16'h000F, 16'h0100, 16'h00FE, 16'h00FF, 16'h03A8};

   assign bus.mul_ready        = !pending && !forceNotReady;
   assign bus.mul_result_valid = pending || forceResValid;
   assign bus.mul_result       = pending ? prod : 16'h0000;

   // Multiplier model: collects A then B, holds the product until acknowledged.
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         gotA    <= 1'b0;
         pending <= 1'b0;
         opA     <= 8'h00;
         prod    <= 16'h0000;
      end else begin
         if (bus.mul_put && bus.mul_ready) begin
            if (!gotA) begin
               opA  <= bus.mul_idata;
               gotA <= 1'b1;
            end else begin
               prod    <= {8'h00, opA} * {8'h00, bus.mul_idata};
               pending <= 1'b1;
               gotA    <= 1'b0;
            end
         end
         if (bus.mul_get) pending <= 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " in_ready"},   32'(bus.in_ready),   32'd1);
      checkOutput({tag, " mul_put"},    32'(bus.mul_put),    32'd0);
      checkOutput({tag, " mul_idata"},  32'(bus.mul_idata),  32'd0);
      checkOutput({tag, " mul_get"},    32'(bus.mul_get),    32'd0);
      checkOutput({tag, " out_valid"},  32'(bus.out_valid),  32'd0);
      checkOutput({tag, " out_data"},   32'(bus.out_data),   32'd0);
      checkOutput({tag, " done_count"}, 32'(bus.done_count), 32'd0);
      checkOutput({tag, " proto_err"},  32'(bus.proto_err),  32'd0);
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic waitProduct(input string tag, input logic [15:0] expected);
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, " out_data"},  32'(bus.out_data),  32'(expected));
      @(negedge clk);
   endtask

   initial begin
      rst_b         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = 8'h00;
      bus.in_b      = 8'h00;
      bus.out_ready = 1'b1;
      forceNotReady = 1'b0;
      forceResValid = 1'b0;
      #1 rst_b = 1'b0;
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      rst_b = 1'b1;
      @(negedge clk);

      // Single pair, cycle by cycle latency.
      applyStimulus(8'h0C, 8'h0B);
      checkOutput("lat c1 put", 32'(bus.mul_put), 32'd0);
      @(negedge clk);
      checkOutput("lat c2 put", 32'(bus.mul_put), 32'd1);
      checkOutput("lat c2 idata", 32'(bus.mul_idata), 32'h0C);
      @(negedge clk);
      checkOutput("lat c3 put", 32'(bus.mul_put), 32'd1);
      checkOutput("lat c3 idata", 32'(bus.mul_idata), 32'h0B);
      @(negedge clk);
      checkOutput("lat c4 get", 32'(bus.mul_get), 32'd1);
      checkOutput("lat c4 put", 32'(bus.mul_put), 32'd0);
      checkOutput("lat c4 out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      checkOutput("lat c5 out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("lat c5 out_data", 32'(bus.out_data), 32'h0084);
      checkOutput("lat c5 get", 32'(bus.mul_get), 32'd0);
      @(negedge clk);
      checkOutput("lat c6 out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("lat c6 done_count", 32'(bus.done_count), 32'd1);

      // Operand extremes.
      applyStimulus(8'hFF, 8'hFF);
      waitProduct("max", 16'hFE01);
      applyStimulus(8'h00, 8'hA5);
      waitProduct("zero", 16'h0000);
      checkOutput("extremes done_count", 32'(bus.done_count), 32'd3);

      // Fill with downstream stalled, then try one extra pair while full.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_a = fillA[i];
         bus.in_b = fillB[i];
         @(negedge clk);
      end
      bus.in_a = 8'hEE;
      bus.in_b = 8'hEE;
      checkOutput("full in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      checkOutput("full hold out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("full hold out_data", 32'(bus.out_data), 32'h000F);
      checkOutput("full still in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("full before pop in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      checkOutput("after pop in_ready", 32'(bus.in_ready), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("stall out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall out_data", 32'(bus.out_data), 32'h000F);
      checkOutput("stall proto_err", 32'(bus.proto_err), 32'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) waitProduct($sformatf("drain%0d", i), fillP[i]);
      repeat (12) @(negedge clk);
      checkOutput("drain no extra", 32'(bus.out_valid), 32'd0);
      checkOutput("drain done_count", 32'(bus.done_count), 32'd8);

      // Multiplier back-pressure while sending A.
      applyStimulus(8'h21, 8'h03);
      @(negedge clk);
      forceNotReady = 1'b1;
      checkOutput("bp c0 idata", 32'(bus.mul_idata), 32'h21);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("bp c%0d put", i), 32'(bus.mul_put), 32'd1);
         checkOutput($sformatf("bp c%0d idata", i), 32'(bus.mul_idata), 32'h21);
      end
      forceNotReady = 1'b0;
      waitProduct("bp", 16'h0063);
      checkOutput("bp proto_err", 32'(bus.proto_err), 32'd0);
      checkOutput("bp done_count", 32'(bus.done_count), 32'd9);

      // Reset during SEND_B with three pairs queued.
      bus.in_valid = 1'b1;
      bus.in_a = 8'h11; bus.in_b = 8'h22;
      @(negedge clk);
      bus.in_a = 8'h33; bus.in_b = 8'h44;
      @(negedge clk);
      bus.in_a = 8'h55; bus.in_b = 8'h66;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("mid SEND_B idata", 32'(bus.mul_idata), 32'h22);
      #1 rst_b = 1'b0;
      #1 checkResetValues("midreset");
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      applyStimulus(8'h0A, 8'h0A);
      waitProduct("post reset", 16'h0064);
      checkOutput("post reset done_count", 32'(bus.done_count), 32'd1);
      repeat (12) @(negedge clk);
      checkOutput("no replay out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("no replay done_count", 32'(bus.done_count), 32'd1);

      // Result-valid during SEND_A must set the sticky error.
      applyStimulus(8'h05, 8'h07);
      @(negedge clk);
      checkOutput("err before", 32'(bus.proto_err), 32'd0);
      forceResValid = 1'b1;
      @(negedge clk);
      forceResValid = 1'b0;
      checkOutput("err set", 32'(bus.proto_err), 32'd1);
      waitProduct("err pair", 16'h0023);
      repeat (5) @(negedge clk);
      checkOutput("err sticky", 32'(bus.proto_err), 32'd1);
      #1 rst_b = 1'b0;
      #1 checkResetValues("err reset");
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      checkOutput("err after reset", 32'(bus.proto_err), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
